// File: rtl/spoc_bdi_block_packer.sv
// spoc_bdi_block_packer: gathers CCW-bit bdi words into BLK_WORDS-word rate blocks with
// byte masking, 10* padding and a block handshake that can reload while unloading.
module spoc_bdi_block_packer #(
    parameter int         CCW       = 32,
    parameter int         BLK_WORDS = 2,
    parameter logic [7:0] PAD_BYTE  = 8'h80,
    localparam int        BW        = CCW * BLK_WORDS,
    localparam int        NB        = CCW / 8,
    localparam int        NBW       = $clog2(BW / 8 + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CCW-1:0]  bdi,
    input  logic            bdi_valid,
    output logic            bdi_ready,
    input  logic [NB-1:0]   bdi_valid_bytes,
    input  logic [3:0]      bdi_type,
    input  logic            bdi_eot,
    input  logic            bdi_eoi,
    output logic [BW-1:0]   blk_data,
    output logic            blk_valid,
    input  logic            blk_ready,
    output logic [3:0]      blk_type,
    output logic [NBW-1:0]  blk_nbytes,
    output logic            blk_partial,
    output logic            blk_eot,
    output logic            blk_eoi
);
    localparam int CW = BLK_WORDS > 1 ? $clog2(BLK_WORDS) : 1;
    localparam int PW = $clog2(NB + 1);

    typedef enum logic {FILL, FULL} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx, base_cnt;
    logic [BW-1:0]  base_data, data_nx;
    logic [NBW-1:0] base_nb, nb_nx;
    logic [3:0]     type_nx;
    logic           partial_nx, eot_nx, eoi_nx;
    logic [CCW-1:0] word;
    logic [PW-1:0]  pc;
    logic           hs, last, close, pad_here, pad_next;

    assign bdi_ready = (state == FILL) | blk_ready;
    assign blk_valid = state == FULL;
    assign hs        = bdi_valid & bdi_ready;

    always_comb begin
        // A word accepted while unloading starts a fresh block in slot 0
        base_cnt  = state == FULL ? '0 : cnt;
        base_data = state == FULL ? '0 : blk_data;
        base_nb   = state == FULL ? '0 : blk_nbytes;
        word      = '0;
        pc        = '0;
        for (int j = 0; j < NB; j++) begin
            word[8*j +: 8] = bdi_valid_bytes[j] ? bdi[8*j +: 8] : 8'h00;
            pc = pc + PW'(bdi_valid_bytes[j]);
        end
        last     = int'(base_cnt) == BLK_WORDS - 1;
        close    = bdi_eot | last;
        pad_here = bdi_eot & (int'(pc) < NB);
        pad_next = bdi_eot & (int'(pc) == NB) & ~last;
        for (int j = 0; j < NB; j++)
            if (pad_here && int'(pc) + j == NB - 1) word[8*j +: 8] = PAD_BYTE;
        state_nx   = state;
        cnt_nx     = cnt;
        data_nx    = blk_data;
        nb_nx      = blk_nbytes;
        type_nx    = blk_type;
        partial_nx = blk_partial;
        eot_nx     = blk_eot;
        eoi_nx     = blk_eoi;
        if (hs) begin
            data_nx = base_data;
            for (int k = 0; k < BLK_WORDS; k++) begin
                if (int'(base_cnt) == k) data_nx[(BLK_WORDS-1-k)*CCW +: CCW] = word;
                if (pad_next && int'(base_cnt) + 1 == k)
                    data_nx[(BLK_WORDS-1-k)*CCW + CCW - 8 +: 8] = PAD_BYTE;
            end
            state_nx   = close ? FULL : FILL;
            cnt_nx     = close ? '0 : base_cnt + CW'(1);
            nb_nx      = base_nb + NBW'(pc);
            type_nx    = base_cnt == '0 ? bdi_type : blk_type;
            partial_nx = pad_here | pad_next;
            eot_nx     = close & bdi_eot;
            eoi_nx     = close & bdi_eoi;
        end else if (state == FULL && blk_ready) begin
            state_nx   = FILL;
            cnt_nx     = '0;
            data_nx    = '0;
            nb_nx      = '0;
            type_nx    = '0;
            partial_nx = 1'b0;
            eot_nx     = 1'b0;
            eoi_nx     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= FILL;
        else      state <= state_nx;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt         <= '0;
            blk_data    <= '0;
            blk_nbytes  <= '0;
            blk_type    <= '0;
            blk_partial <= 1'b0;
            blk_eot     <= 1'b0;
            blk_eoi     <= 1'b0;
        end else begin
            cnt         <= cnt_nx;
            blk_data    <= data_nx;
            blk_nbytes  <= nb_nx;
            blk_type    <= type_nx;
            blk_partial <= partial_nx;
            blk_eot     <= eot_nx;
            blk_eoi     <= eoi_nx;
        end
endmodule

// File: tb/tb_spoc_bdi_block_packer.sv
// tb_spoc_bdi_block_packer: directed and random stimulus checked against a byte-array
// reference model of block assembly and a queue of expected blocks.
module tb_spoc_bdi_block_packer;
    localparam int NB   = 4;
    localparam int BLK  = 2;
    localparam int NBYT = NB * BLK;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bdi = '0;
    logic        bdi_valid = 1'b0;
    logic        bdi_ready;
    logic [3:0]  bdi_valid_bytes = '0;
    logic [3:0]  bdi_type = '0;
    logic        bdi_eot = 1'b0;
    logic        bdi_eoi = 1'b0;
    logic [63:0] blk_data;
    logic        blk_valid;
    logic        blk_ready = 1'b0;
    logic [3:0]  blk_type;
    logic [3:0]  blk_nbytes;
    logic        blk_partial;
    logic        blk_eot;
    logic        blk_eoi;

    always #5 clk = ~clk;

    spoc_bdi_block_packer #(.CCW(32), .BLK_WORDS(2), .PAD_BYTE(8'h80)) dut (
        .clk(clk), .rst(rst), .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready),
        .bdi_valid_bytes(bdi_valid_bytes), .bdi_type(bdi_type), .bdi_eot(bdi_eot),
        .bdi_eoi(bdi_eoi), .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_type(blk_type), .blk_nbytes(blk_nbytes), .blk_partial(blk_partial),
        .blk_eot(blk_eot), .blk_eoi(blk_eoi)
    );

    typedef struct {
        logic [63:0] data;
        logic [3:0]  nb;
        logic        partial;
        logic [3:0]  typ;
        logic        eot;
        logic        eoi;
    } blk_t;

    blk_t       q[$];
    logic [7:0] m_bytes[NBYT];
    int         m_cnt, m_nb;
    logic [3:0] m_type;
    int         pass_cnt = 0, fail_cnt = 0, total = 0;
    logic       acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < NBYT; b++) m_bytes[b] = 8'h00;
        m_cnt = 0;
        m_nb  = 0;
    endtask

    // Byte-level view: slot k byte i (from MSB) is block byte k*NB+i; the pad byte
    // lands right after the last valid byte if that position is still inside the block.
    task automatic model_accept(input logic [31:0] w, input logic [3:0] m, input logic [3:0] t,
                                input logic e, input logic i);
        int   pc;
        blk_t b;
        pc = 0;
        if (m_cnt == 0) m_type = t;
        for (int k = 0; k < NB; k++) begin
            m_bytes[m_cnt*NB + k] = m[NB-1-k] ? w[31-8*k -: 8] : 8'h00;
            if (m[NB-1-k]) pc++;
        end
        m_nb += pc;
        if (e || m_cnt == BLK - 1) begin
            b.partial = 1'b0;
            if (e && m_cnt*NB + pc < NBYT) begin
                m_bytes[m_cnt*NB + pc] = 8'h80;
                b.partial = 1'b1;
            end
            b.data = '0;
            for (int k = 0; k < NBYT; k++) b.data = {b.data[55:0], m_bytes[k]};
            b.nb  = 4'(m_nb);
            b.typ = m_type;
            b.eot = e;
            b.eoi = i;
            q.push_back(b);
            model_clear();
        end else m_cnt++;
    endtask

    task automatic cyc(input logic v, input logic [31:0] w, input logic [3:0] m, input logic [3:0] t,
                       input logic e, input logic i, input logic r);
        logic exp_rdy;
        bdi_valid = v; bdi = w; bdi_valid_bytes = m; bdi_type = t;
        bdi_eot = e; bdi_eoi = i; blk_ready = r;
        @(negedge clk);
        exp_rdy = (q.size() == 0) || r;
        chk("bdi_ready", 64'(bdi_ready), 64'(exp_rdy));
        chk("blk_valid", 64'(blk_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("blk_data", blk_data, q[0].data);
            chk("blk_nbytes", 64'(blk_nbytes), 64'(q[0].nb));
            chk("blk_partial", 64'(blk_partial), 64'(q[0].partial));
            chk("blk_type", 64'(blk_type), 64'(q[0].typ));
            chk("blk_eot", 64'(blk_eot), 64'(q[0].eot));
            chk("blk_eoi", 64'(blk_eoi), 64'(q[0].eoi));
            if (r) void'(q.pop_front());
        end
        acc = v && exp_rdy;
        if (acc) model_accept(w, m, t, e, i);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] seg_type, mk;
        logic       v, e, r;
        model_clear();
        m_type = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_valid", 64'(blk_valid), 64'd0);
        chk("rst_ready", 64'(bdi_ready), 64'd1);
        chk("rst_data", blk_data, 64'd0);

        cyc(1, 32'hCAFEBABE, 4'hF, 4'h2, 0, 0, 0);
        rst = 1'b0;
        #2;
        chk("midrst_valid", 64'(blk_valid), 64'd0);
        chk("midrst_ready", 64'(bdi_ready), 64'd1);
        chk("midrst_data", blk_data, 64'd0);
        chk("midrst_nbytes", 64'(blk_nbytes), 64'd0);
        rst = 1'b1;
        model_clear();
        cyc(1, 32'h11223344, 4'hF, 4'h1, 0, 0, 0);
        cyc(1, 32'h55667788, 4'hF, 4'h1, 0, 0, 0);
        chk("tp1_data", blk_data, 64'h1122334455667788);
        chk("tp1_nbytes", 64'(blk_nbytes), 64'd8);
        chk("tp1_partial", 64'(blk_partial), 64'd0);
        cyc(0, 32'h0, 4'h0, 4'h0, 0, 0, 1);

        cyc(1, 32'h11223344, 4'hF, 4'h4, 0, 0, 0);
        cyc(1, 32'hAABBCCDD, 4'hF, 4'h4, 1, 1, 0);
        chk("tp2_valid", 64'(blk_valid), 64'd1);
        chk("tp2_data", blk_data, 64'h11223344AABBCCDD);
        chk("tp2_nbytes", 64'(blk_nbytes), 64'd8);
        chk("tp2_partial", 64'(blk_partial), 64'd0);
        chk("tp2_eot", 64'(blk_eot), 64'd1);
        chk("tp2_eoi", 64'(blk_eoi), 64'd1);
        chk("tp2_type", 64'(blk_type), 64'd4);
        cyc(0, 32'h0, 4'h0, 4'h0, 0, 0, 1);

        cyc(1, 32'h11223344, 4'hC, 4'h3, 1, 0, 0);
        chk("tp3_data", blk_data, 64'h1122800000000000);
        chk("tp3_nbytes", 64'(blk_nbytes), 64'd2);
        chk("tp3_partial", 64'(blk_partial), 64'd1);
        cyc(0, 32'h0, 4'h0, 4'h0, 0, 0, 1);

        cyc(1, 32'hDEADBEEF, 4'hF, 4'h3, 1, 0, 0);
        chk("tp4_data", blk_data, 64'hDEADBEEF80000000);
        chk("tp4_nbytes", 64'(blk_nbytes), 64'd4);
        chk("tp4_partial", 64'(blk_partial), 64'd1);
        cyc(0, 32'h0, 4'h0, 4'h0, 0, 0, 1);

        cyc(1, 32'hFFFFFFFF, 4'h0, 4'h3, 1, 0, 0);
        chk("tp5_data", blk_data, 64'h8000000000000000);
        chk("tp5_nbytes", 64'(blk_nbytes), 64'd0);
        chk("tp5_partial", 64'(blk_partial), 64'd1);
        cyc(0, 32'h0, 4'h0, 4'h0, 0, 0, 1);

        cyc(1, 32'h01020304, 4'hF, 4'h5, 0, 0, 1);
        cyc(1, 32'h05060708, 4'hF, 4'h5, 0, 0, 1);
        chk("b2b_blk0", blk_data, 64'h0102030405060708);
        cyc(1, 32'h090A0B0C, 4'hF, 4'h5, 0, 0, 1);
        cyc(1, 32'h0D0E0F10, 4'hF, 4'h5, 0, 0, 1);
        chk("b2b_blk1_valid", 64'(blk_valid), 64'd1);
        for (int s = 0; s < 3; s++) begin
            cyc(1, 32'h11111111, 4'hF, 4'h5, 0, 0, 0);
            chk("stall_data", blk_data, 64'h090A0B0C0D0E0F10);
            chk("stall_ready", 64'(bdi_ready), 64'd0);
        end
        cyc(1, 32'h11111111, 4'hF, 4'h5, 0, 0, 1);
        cyc(1, 32'h22222222, 4'hF, 4'h5, 1, 1, 1);
        cyc(0, 32'h0, 4'h0, 4'h0, 0, 0, 1);

        seg_type = 4'($urandom_range(0, 15));
        for (int n = 0; n < 500; n++) begin
            v  = $urandom_range(0, 3) != 0;
            r  = $urandom_range(0, 2) != 0;
            e  = $urandom_range(0, 3) == 0;
            mk = 4'hF;
            if (e && $urandom_range(0, 1) == 1) mk = 4'hF << (4 - $urandom_range(0, 3));
            cyc(v, $urandom, mk, seg_type, e, e && ($urandom_range(0, 1) == 1), r);
            if (acc && e) seg_type = 4'($urandom_range(0, 15));
        end
        for (int n = 0; n < 4 && q.size() != 0; n++) cyc(0, 32'h0, 4'h0, 4'h0, 0, 0, 1);
        chk("drain_empty", 64'(blk_valid), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/spoc_bdi_block_packer.md
Name: spoc_bdi_block_packer

Overview:
- Parametrised input-side block assembler placed between the PreProcessor bdi interface and the SpoC permutation datapath.
- Gathers CCW-bit bdi words into one rate block of BLK_WORDS words. Applies byte masking and 10* padding, and presents the block with type, length and end flags over a valid/ready handshake.
- Successor to the fixed 32-bit/64-bit-rate bdi path: word width, block depth and pad byte are generic, and a block can be unloaded in the same cycle the next block's first word is accepted.

Parameters:
- CCW, 32, bdi word width in bits; one of 8, 16, 32, 64.
- BLK_WORDS, 2, words per rate block; 1 to 8. Block width BW = CCW*BLK_WORDS.
- PAD_BYTE, 8'h80, byte inserted directly after the last valid message byte.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- bdi  in  CCW  input word; first byte is at the MSBs.
- bdi_valid  in  1  input word valid.
- bdi_ready  out  1  input word accepted when high together with bdi_valid.
- bdi_valid_bytes  in  CCW/8  contiguous MSB-first byte-valid mask.
- bdi_type  in  4  segment type.
- bdi_eot  in  1  last word of segment.
- bdi_eoi  in  1  last word of input.
- blk_data  out  BW  assembled block; slot 0 occupies the MSBs.
- blk_valid  out  1  block available.
- blk_ready  in  1  downstream consumes the block.
- blk_type  out  4  type of the block's first word.
- blk_nbytes  out  clog2(BW/8+1)  count of valid message bytes.
- blk_partial  out  1  block contains padding.
- blk_eot  out  1  block closes its segment.
- blk_eoi  out  1  block closes the input.

Behaviour:
- Reset (rst=0, asynchronous), from any state including mid-block:
  - state=FILL, cnt=0, blk_data=0, blk_valid=0, blk_nbytes=0, blk_partial=0, blk_type=0, blk_eot=0, blk_eoi=0.
  - bdi_ready=1 after reset.
- States: FILL and FULL.
- bdi_ready = (state==FILL) | blk_ready.
- FILL, on a handshake:
  - Write the word into slot cnt. Bytes whose valid bit is 0 are forced to 0.
  - nbytes += popcount(bdi_valid_bytes).
  - If cnt==0, latch blk_type.
- Close condition: bdi_eot=1, or cnt==BLK_WORDS-1.
  - If not closing: cnt++ and stay in FILL.
  - If closing: go to FULL, latch blk_eot=bdi_eot and blk_eoi=bdi_eoi, clear cnt.
- Padding on an eot close, applied in the same cycle:
  - If the word is partial, PAD_BYTE goes into the first invalid byte.
  - If the word is full and cnt<BLK_WORDS-1, PAD_BYTE goes into the MSB byte of slot cnt+1.
  - All remaining bytes are 0.
  - blk_partial=1 iff PAD_BYTE was inserted.
  - A full word in the last slot gets no pad and blk_partial=0.
- A close caused only by a full block (no eot) never pads.
- Empty segment: cnt==0, bdi_valid_bytes=0, bdi_eot=1. Result: blk_data = PAD_BYTE in the top byte, blk_nbytes=0, blk_partial=1.
- Latency: the closing word is accepted in cycle N; blk_valid=1 from cycle N+1.
- FULL: blk_valid=1. Outputs are held stable until blk_ready=1.
  - blk_ready=1 with no bdi handshake: next state FILL, block registers cleared.
  - blk_ready=1 with a bdi handshake in the same cycle: block registers are reloaded as slot 0 of the new block (others 0, nbytes = that word's count). Next state is FULL if this word closes, otherwise FILL with cnt=1.
  - This gives zero bubbles at full rate.
- bdi_eot/bdi_eoi on a non-last word while cnt>0: closes normally.
- A type change without a preceding eot is a protocol violation. Behaviour is undefined and is not checked.
- BLK_WORDS=1: every accepted word closes a block.

Test Plan (CCW=32, BLK_WORDS=2, PAD_BYTE=8'h80):
- Reset asserted mid-block (one word loaded), then released -> blk_valid=0, bdi_ready=1. The next two words 11223344, 55667788 produce a block from a clean start: 1122334455667788, nbytes=8, partial=0.
- Words 11223344 (mask F), AABBCCDD (mask F, eot, eoi), type=4 -> after one cycle: blk_valid=1, blk_data=11223344AABBCCDD, nbytes=8, partial=0, eot=1, eoi=1, type=4.
- Word 11223344 (mask C, eot) -> blk_data=1122800000000000, nbytes=2, partial=1.
- Word DEADBEEF (mask F, eot) -> blk_data=DEADBEEF80000000, nbytes=4, partial=1.
- Empty segment (mask 0, eot) -> blk_data=8000000000000000, nbytes=0, partial=1.
- Four back-to-back full words, blk_ready held 1, bdi_valid held 1 -> bdi_ready never drops. Two blocks are emitted one cycle after each closing word, with no bubble. With blk_ready=0 for 3 cycles: bdi_ready=0 and blk_data stays stable.
